layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//   Generalised, pipelined pixel compositor for the VGA render path: merges a background colour and
//   NUM_LAYERS sprite layers (scene objects, clouds, apples, kid) by fixed priority into rgb_out.
//   Adds a per-layer enable, colour-key transparency and per-frame collision detection between one
//   player layer and a hazard set. Sits between the sprite modules and the VGA driver.
// PARAMETERS
//   NUM_LAYERS   19        sprite layer count; layer index N-1 has highest priority
//   COLOR_W      12        bits per pixel (4:4:4)
//   KEY_COLOR    12'h0F0   layer pixels equal to this colour are transparent
//   PLAYER_IDX   18        layer index treated as the player for collision
//   HAZARD_MASK  {N{1'b0}} bit j=1: layer j is a hazard against the player
//   H_ACTIVE     640       visible columns; V_ACTIVE 480 visible rows
// PORTS
//   clk           in   1              pixel clock
//   rst_n         in   1              asynchronous reset, active low
//   col, row      in   10, 10         current pixel coordinate
//   pix_valid     in   1              1 = coordinate inside visible area
//   bg_rgb        in   COLOR_W        background (scene) colour for this pixel
//   layer_hit     in   NUM_LAYERS     bit j: layer j covers this pixel
//   layer_rgb     in   NUM_LAYERS*COLOR_W  layer j colour in bits [j*COLOR_W +: COLOR_W]
//   layer_en      in   NUM_LAYERS     bit j=0: layer j ignored (draw and collision)
//   rgb_out       out  COLOR_W        composited pixel, 2-cycle latency
//   rgb_valid     out  1              pix_valid delayed 2 cycles
//   collide_mask  out  NUM_LAYERS     hazards that overlapped player during last complete frame
//   collide_pulse out  1              1-cycle pulse at frame end when collide_mask != 0
//   frame_cnt     out  16             completed frames since reset, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//   Reset (rst_n=0, async): all outputs 0; pipeline, accumulator, armed flag cleared.
//   Stage 1 (cycle t+1): eff[j] = layer_hit[j] & layer_en[j] & (layer_rgb[j] != KEY_COLOR) & pix_valid;
//     register eff-any, winning index (highest set bit of eff), bg_rgb, pix_valid, frame-end flag.
//   Stage 2 (cycle t+2): rgb_out = winner colour if any eff bit, else bg_rgb; rgb_out = 0 when
//     stage-1 pix_valid=0. rgb_valid mirrors it. Throughput 1 pixel/cycle, no stalls.
//   Collision (stage 1): hz = eff & HAZARD_MASK & {N{eff[PLAYER_IDX]}}, PLAYER_IDX bit forced 0;
//     acc <= acc | hz every valid pixel while armed.
//   Key-coloured or disabled pixels never collide (transparency = no hitbox).
//   Frame start = pix_valid & col==0 & row==0: sets armed; acc cleared (the start pixel's hz is kept).
//   Frame end = pix_valid & col==H_ACTIVE-1 & row==V_ACTIVE-1: if armed, next cycle
//     collide_mask <= acc|hz (end pixel included), collide_pulse=1 iff that value !=0,
//     frame_cnt++; acc cleared. If not armed, frame end ignored (no pulse, no count).
//   collide_mask holds until next reported frame end. Reset mid-frame: armed=0, so the
//     partial frame after reset is never reported.
//   Frame start and end in same cycle (only if H_ACTIVE=V_ACTIVE=1): start processed first.
//   Width rules: index register $clog2(NUM_LAYERS) bits; counter wraps silently.
// STRUCTURE
//   render_pkg: COLOR_W, H_ACTIVE, V_ACTIVE, KEY_COLOR default, LAYER_W=$clog2 helper, rgb_t typedef.
//   Sub-module prio_enc_msb #(W): combinational highest-set-bit encoder -> {any, idx}.
//   Top: two pipeline register banks, collision accumulator, armed flag, frame counter.
// TESTING
//   1 no hits, bg_rgb=12'h48C -> rgb_out=12'h48C exactly 2 cycles later, rgb_valid=1.
//   2 layers 3 (12'hF00) and 7 (12'h00F) hit same pixel -> 12'h00F; disable layer 7 -> 12'hF00.
//   3 layer 7 hit with colour KEY_COLOR, layer 3 hit 12'hF00 -> 12'hF00; pix_valid=0 -> rgb_out=0.
//   4 HAZARD_MASK bit 5 set; player and layer 5 overlap one pixel in frame -> at end collide_mask=
//     bit5, collide_pulse 1 cycle, frame_cnt=1; next clean frame -> mask 0, no pulse, frame_cnt=2.
//   5 overlap only at last pixel (639,479) -> reported in that frame's collide_mask.
//   6 assert rst_n mid-frame with overlap pending -> outputs 0 immediately; partial frame not
//     reported; first full frame after reset reports correctly, frame_cnt=1.

Source files
------------

// File: rtl/layer_compositor_pkg.sv
// Shared constants, pixel type and width helper
// for the layered VGA compositor.
package layer_compositor_pkg;

  localparam int RGB_W = 12;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam logic [RGB_W-1:0] KEY_DEF = 12'h0F0;

  typedef logic [RGB_W-1:0] rgb_t;

  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_compositor_prio_enc_msb.sv
// Combinational highest-set-bit encoder:
// returns whether any request is set and its top index.
module prio_enc_msb
  import layer_compositor_pkg::*;
#(
  parameter int W = 19,
  localparam int IW = layer_w(W)
) (
  input  logic [W-1:0]  i_req,
  output logic          o_any,
  output logic [IW-1:0] o_idx
);

  // Later (higher) bits overwrite earlier ones.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (i_req[i]) o_idx = IW'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage priority compositor with colour-key transparency
// and per-frame player/hazard collision reporting.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int                    NUM_LAYERS  = 19,
  parameter int                    COLOR_W     = RGB_W,
  parameter logic [COLOR_W-1:0]    KEY_COLOR   = KEY_DEF,
  parameter int                    PLAYER_IDX  = 18,
  parameter logic [NUM_LAYERS-1:0] HAZARD_MASK = '0,
  parameter int                    H_ACTIVE    = H_ACT,
  parameter int                    V_ACTIVE    = V_ACT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    col,
  input  logic [9:0]                    row,
  input  logic                          pix_valid,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [COLOR_W-1:0]            rgb_out,
  output logic                          rgb_valid,
  output logic [NUM_LAYERS-1:0]         collide_mask,
  output logic                          collide_pulse,
  output logic [15:0]                   frame_cnt
);

  localparam int LW = layer_w(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] w_eff;
  logic [NUM_LAYERS-1:0] w_hz;
  logic [NUM_LAYERS-1:0] w_acc_nxt;
  logic                  w_any;
  logic [LW-1:0]         w_idx;
  logic                  w_start;
  logic                  w_end;
  logic                  w_armed;

  logic                  r1_valid;
  logic                  r1_any;
  logic [LW-1:0]         r1_idx;
  logic [COLOR_W-1:0]    r1_bg;
  logic [COLOR_W-1:0]    r1_lyr [NUM_LAYERS];

  logic [COLOR_W-1:0]    r_rgb;
  logic                  r_rgb_valid;
  logic [NUM_LAYERS-1:0] r_acc;
  logic                  r_armed;
  logic [NUM_LAYERS-1:0] r_mask;
  logic                  r_pulse;
  logic [15:0]           r_frame_cnt;

  always_comb begin
    w_eff = '0;
    for (int j = 0; j < NUM_LAYERS; j++) begin
      w_eff[j] = layer_hit[j] & layer_en[j] & pix_valid
               & (layer_rgb[j*COLOR_W +: COLOR_W] != KEY_COLOR);
    end
  end

  // The player never counts as its own hazard.
  always_comb begin
    w_hz = w_eff & HAZARD_MASK
         & {NUM_LAYERS{w_eff[PLAYER_IDX]}};
    w_hz[PLAYER_IDX] = 1'b0;
  end

  prio_enc_msb #(
    .W (NUM_LAYERS)
  ) u_prio (
    .i_req (w_eff),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  assign w_start = pix_valid & (col == '0) & (row == '0);
  assign w_end   = pix_valid
                 & (col == 10'(H_ACTIVE - 1))
                 & (row == 10'(V_ACTIVE - 1));
  assign w_armed   = r_armed | w_start;
  assign w_acc_nxt = (w_start ? '0 : r_acc) | w_hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_any   <= 1'b0;
      r1_idx   <= '0;
      r1_bg    <= '0;
      r1_lyr   <= '{default: '0};
    end else begin
      r1_valid <= pix_valid;
      r1_any   <= w_any;
      r1_idx   <= w_idx;
      r1_bg    <= bg_rgb;
      for (int j = 0; j < NUM_LAYERS; j++) begin
        r1_lyr[j] <= layer_rgb[j*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= r1_valid;
      if (!r1_valid)   r_rgb <= '0;
      else if (r1_any) r_rgb <= r1_lyr[r1_idx];
      else             r_rgb <= r1_bg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_armed     <= 1'b0;
      r_mask      <= '0;
      r_pulse     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_start) r_armed <= 1'b1;
      if (w_end && w_armed) begin
        r_mask      <= w_acc_nxt;
        r_pulse     <= |w_acc_nxt;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_acc       <= '0;
      end else if (w_armed) begin
        r_acc <= w_acc_nxt;
      end
    end
  end

  assign rgb_out       = r_rgb;
  assign rgb_valid     = r_rgb_valid;
  assign collide_mask  = r_mask;
  assign collide_pulse = r_pulse;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed plus random checks of the compositor
// against a behavioural pixel/frame model.
module tb_layer_compositor;
  import layer_compositor_pkg::*;

  localparam int N  = 19;
  localparam int CW = 12;
  localparam int PL = 18;
  localparam logic [N-1:0]  HZ  = 19'h00020;
  localparam logic [CW-1:0] KEY = 12'h0F0;
  localparam logic [N-1:0]  ALL = '1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [9:0]      col, row;
  logic            pix_valid;
  logic [CW-1:0]   bg_rgb;
  logic [N-1:0]    layer_hit, layer_en;
  logic [N*CW-1:0] layer_rgb;
  logic [CW-1:0]   rgb_out;
  logic            rgb_valid;
  logic [N-1:0]    collide_mask;
  logic            collide_pulse;
  logic [15:0]     frame_cnt;

  rgb_t lrgb [N];

  int total = 0;
  int bad   = 0;
  int step  = 0;

  logic [CW-1:0] m_prev_rgb, exp_rgb;
  logic          m_prev_v, exp_v;
  logic          m_armed, m_pulse;
  logic [N-1:0]  m_acc, m_mask;
  logic [15:0]   m_cnt;

  always #5 clk = ~clk;

  always_comb begin
    layer_rgb = '0;
    for (int j = 0; j < N; j++) layer_rgb[j*CW +: CW] = lrgb[j];
  end

  layer_compositor #(
    .HAZARD_MASK (HZ)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .col           (col),
    .row           (row),
    .pix_valid     (pix_valid),
    .bg_rgb        (bg_rgb),
    .layer_hit     (layer_hit),
    .layer_rgb     (layer_rgb),
    .layer_en      (layer_en),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid),
    .collide_mask  (collide_mask),
    .collide_pulse (collide_pulse),
    .frame_cnt     (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%h expected=%h",
             tag, step, obs, exp);
    end
  endtask

  function automatic logic vis(input int j);
    return pix_valid && layer_hit[j] && layer_en[j] && lrgb[j] != KEY;
  endfunction

  function automatic logic [CW-1:0] ref_rgb();
    if (!pix_valid) return '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (vis(j)) return lrgb[j];
    end
    return bg_rgb;
  endfunction

  function automatic logic [N-1:0] ref_hz();
    logic [N-1:0] h;
    h = '0;
    if (!vis(PL)) return h;
    for (int j = 0; j < N; j++) begin
      if (j != PL && HZ[j] && vis(j)) h[j] = 1'b1;
    end
    return h;
  endfunction

  task automatic model_reset();
    m_prev_rgb = '0; m_prev_v = 1'b0;
    m_armed = 1'b0;  m_acc = '0;
    m_mask = '0;     m_pulse = 1'b0;
    m_cnt = '0;
  endtask

  task automatic check_all();
    chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    chk("rgb_valid", 32'(rgb_valid), 32'(exp_v));
    chk("collide_mask", 32'(collide_mask), 32'(m_mask));
    chk("collide_pulse", 32'(collide_pulse), 32'(m_pulse));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic tick();
    logic [CW-1:0] f;
    logic [N-1:0]  hz;
    logic          st, en;
    f  = ref_rgb();
    hz = ref_hz();
    st = pix_valid && col == 0 && row == 0;
    en = pix_valid && col == 639 && row == 479;
    @(posedge clk);
    step++;
    exp_rgb = m_prev_rgb; exp_v = m_prev_v;
    m_prev_rgb = f;       m_prev_v = pix_valid;
    m_pulse = 1'b0;
    if (st) begin
      m_armed = 1'b1;
      m_acc = hz;
    end else if (m_armed) begin
      m_acc = m_acc | hz;
    end
    if (en && m_armed) begin
      m_mask = m_acc;
      m_pulse = (m_acc != 0);
      m_cnt = m_cnt + 16'd1;
      m_acc = '0;
    end
    #1;
    check_all();
  endtask

  task automatic px(input logic v, input int c, input int r,
                    input logic [CW-1:0] bg, input logic [N-1:0] hit,
                    input logic [N-1:0] en);
    pix_valid = v; col = 10'(c); row = 10'(r);
    bg_rgb = bg; layer_hit = hit; layer_en = en;
    tick();
  endtask

  localparam logic [N-1:0] P5 = (19'd1 << 18) | (19'd1 << 5);

  initial begin
    for (int j = 0; j < N; j++) lrgb[j] = rgb_t'(12'h100 + j);
    pix_valid = 0; col = 0; row = 0; bg_rgb = 0;
    layer_hit = 0; layer_en = 0;
    model_reset();
    exp_rgb = '0; exp_v = 1'b0;
    #12;
    check_all();
    rst_n = 1'b1;

    // background only
    px(1, 5, 5, 12'h48C, '0, ALL);
    px(0, 6, 5, 12'h000, '0, ALL);
    chk("t1_rgb", 32'(rgb_out), 32'h48C);
    chk("t1_valid", 32'(rgb_valid), 32'h1);

    // priority and enable
    lrgb[3] = 12'hF00; lrgb[7] = 12'h00F;
    px(1, 7, 7, 12'h111, 19'h88, ALL);
    px(1, 8, 7, 12'h111, 19'h88, ALL & ~19'h80);
    chk("t2_hi", 32'(rgb_out), 32'h00F);
    px(1, 9, 7, 12'h111, '0, ALL);
    chk("t2_dis", 32'(rgb_out), 32'hF00);

    // colour key and invalid pixel
    lrgb[7] = KEY;
    px(1, 10, 7, 12'h111, 19'h88, ALL);
    px(0, 11, 7, 12'h222, 19'h88, ALL);
    chk("t3_key", 32'(rgb_out), 32'hF00);
    px(0, 12, 7, 12'h222, '0, ALL);
    chk("t3_inv", 32'(rgb_out), 32'h000);
    lrgb[7] = 12'h00F;

    // collision frame then clean frame
    lrgb[18] = 12'h333; lrgb[5] = 12'h555; lrgb[4] = 12'h444;
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 10, 10, 12'h010, P5, ALL);
    px(1, 20, 20, 12'h010, '0, ALL);
    px(1, 639, 479, 12'h010, '0, ALL);
    chk("t4_mask", 32'(collide_mask), 32'h20);
    chk("t4_pulse", 32'(collide_pulse), 32'h1);
    chk("t4_cnt", 32'(frame_cnt), 32'd1);
    px(0, 0, 0, 12'h000, '0, ALL);
    chk("t4_pulse_off", 32'(collide_pulse), 32'h0);
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 30, 30, 12'h010, (19'd1 << 18) | 19'h10, ALL);
    px(1, 31, 30, 12'h010, P5, ALL & ~19'h20);
    px(1, 639, 479, 12'h010, '0, ALL);
    chk("t4_clean", 32'(collide_mask), 32'h0);
    chk("t4_cnt2", 32'(frame_cnt), 32'd2);

    // overlap only on last pixel, then only on first pixel
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 639, 479, 12'h010, P5, ALL);
    chk("t5_last", 32'(collide_mask), 32'h20);
    px(1, 0, 0, 12'h010, P5, ALL);
    px(1, 639, 479, 12'h010, '0, ALL);
    chk("t5_first", 32'(collide_mask), 32'h20);
    lrgb[5] = KEY;
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 40, 40, 12'h010, P5, ALL);
    px(1, 639, 479, 12'h010, '0, ALL);
    chk("t5_keyed", 32'(collide_mask), 32'h0);
    lrgb[5] = 12'h555;

    // random pixels
    for (int k = 0; k < 80; k++) begin
      for (int j = 0; j < N; j++) begin
        lrgb[j] = ($urandom_range(0, 4) == 0) ? KEY : rgb_t'($urandom);
      end
      px($urandom_range(0, 5) != 0,
         $urandom_range(1, 638), $urandom_range(1, 478),
         CW'($urandom), N'($urandom), N'($urandom | $urandom));
    end
    lrgb[18] = 12'h333; lrgb[5] = 12'h555;

    // asynchronous reset mid-frame
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 50, 50, 12'h010, P5, ALL);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_rgb = '0; exp_v = 1'b0;
    check_all();
    #1 rst_n = 1'b1;
    px(1, 60, 60, 12'h010, P5, ALL);
    px(1, 639, 479, 12'h010, P5, ALL);
    chk("t6_partial", 32'(frame_cnt), 32'd0);
    px(1, 0, 0, 12'h010, '0, ALL);
    px(1, 70, 70, 12'h010, P5, ALL);
    px(1, 639, 479, 12'h010, '0, ALL);
    chk("t6_cnt", 32'(frame_cnt), 32'd1);
    chk("t6_mask", 32'(collide_mask), 32'h20);
    px(0, 0, 0, 12'h000, '0, ALL);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
